mem_access_master: RTL and testbench

Command-driven initiator for the 64-word × 32-bit `memory_module_128bit` array. Accepts single or burst read/write commands from a host over a valid/ready handshake. Sequences the memory's `data`/`address`/`rE`/`wE` pins and returns read words on a response stream. It sits between the datapath or test sequencer and the memory, so nothing else drives the memory pins directly.

---
 rtl/mem_access_master_if.sv | 35 +++
 rtl/mem_access_master.sv | 134 +++++++++++++
 tb/tb_mem_access_master.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_master_if.sv
// Bundle of the host command/data streams and the memory pin group for
// mem_access_master.
//   master : the initiator's view (drives cmd_ready, wdata_ready, rdata,
//            rdata_valid, done and the mem_* pins; samples mem_dataOut)
//   slave  : the environment's view (host + memory side)
interface mem_access_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [5:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic [31:0] wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic [31:0] mem_data;
  logic [5:0]  mem_address;
  logic        mem_rE;
  logic        mem_wE;
  logic [31:0] mem_dataOut;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid, mem_dataOut,
    output cmd_ready, wdata_ready, rdata, rdata_valid, done,
           mem_data, mem_address, mem_rE, mem_wE
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid, mem_dataOut,
    input  cmd_ready, wdata_ready, rdata, rdata_valid, done,
           mem_data, mem_address, mem_rE, mem_wE
  );
endinterface

// File: rtl/mem_access_master.sv
// Command-driven initiator for the 64 x 32 memory array. Accepts single or
// burst read/write commands over a valid/ready handshake, sequences the
// memory data/address/rE/wE pins and returns read words as a pulse stream.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : master modport (host command/write/read streams + memory pins)
//   READ_LATENCY : cycles from mem_rE high until mem_dataOut holds the word (1..4)
module mem_access_master #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clock,
  input  logic reset,
  mem_access_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  // Reads younger than the one about to be captured: mem_re_q plus the
  // in-flight stages below index READ_LATENCY-1.
  localparam logic [READ_LATENCY:0] OLDER_MASK =
    (READ_LATENCY + 1)'((1 << (READ_LATENCY - 1)) - 1);

  state_t            state_q, state_d;
  logic [5:0]        cur_addr_q, cur_addr_d;
  logic [3:0]        remaining_q, remaining_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic [5:0]        mem_address_q, mem_address_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic              done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  // Stage i is high READ_LATENCY... i+1 cycles after mem_rE; the top stage is rdata_valid.
  logic [READ_LATENCY:0] inflight_q, inflight_d;

  logic cmd_ready;
  logic older_pending;

  // done_q keeps the completion cycle closed so a new command lands one cycle later.
  assign cmd_ready = (state_q == IDLE) && !done_q;

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    mem_data_d    = mem_data_q;
    mem_address_d = mem_address_q;
    mem_re_d      = 1'b0;
    mem_we_d      = 1'b0;
    done_d        = 1'b0;

    inflight_d    = {inflight_q[READ_LATENCY-1:0], mem_re_q};
    rdata_d       = inflight_q[READ_LATENCY-1] ? bus.mem_dataOut : rdata_q;
    older_pending = mem_re_q || ((inflight_q & OLDER_MASK) != '0);

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          cur_addr_d  = bus.cmd_addr;
          remaining_d = bus.cmd_len;
          state_d     = bus.cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (bus.wdata_valid) begin
          mem_we_d      = 1'b1;
          mem_data_d    = bus.wdata;
          mem_address_d = cur_addr_q;
          cur_addr_d    = cur_addr_q + 6'd1;
          if (remaining_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            remaining_d = remaining_q - 4'd1;
          end
        end
      end
      READ: begin
        mem_re_d      = 1'b1;
        mem_address_d = cur_addr_q;
        cur_addr_d    = cur_addr_q + 6'd1;
        if (remaining_q == '0) begin
          state_d = DRAIN;
        end else begin
          remaining_d = remaining_q - 4'd1;
        end
      end
      DRAIN: begin
        // Final word is being captured now; done lines up with its rdata_valid.
        if (inflight_q[READ_LATENCY-1] && !older_pending) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      mem_data_q    <= '0;
      mem_address_q <= '0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      done_q        <= 1'b0;
      rdata_q       <= '0;
      inflight_q    <= '0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      mem_data_q    <= mem_data_d;
      mem_address_q <= mem_address_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      inflight_q    <= inflight_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.wdata_ready = (state_q == WRITE);
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = inflight_q[READ_LATENCY];
  assign bus.done        = done_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_rE      = mem_re_q;
  assign bus.mem_wE      = mem_we_q;

endmodule

// File: tb/tb_mem_access_master.sv
module tb_mem_access_master;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // sel = 0 exercises the READ_LATENCY=1 instance, sel = 1 the READ_LATENCY=3 one.
  logic        sel;
  logic        cmd_valid, cmd_write, wdata_valid;
  logic [5:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic [31:0] wdata;

  mem_access_master_if bus1();
  mem_access_master_if bus3();

  assign bus1.cmd_valid   = cmd_valid & ~sel;
  assign bus1.cmd_write   = cmd_write;
  assign bus1.cmd_addr    = cmd_addr;
  assign bus1.cmd_len     = cmd_len;
  assign bus1.wdata       = wdata;
  assign bus1.wdata_valid = wdata_valid & ~sel;

  assign bus3.cmd_valid   = cmd_valid & sel;
  assign bus3.cmd_write   = cmd_write;
  assign bus3.cmd_addr    = cmd_addr;
  assign bus3.cmd_len     = cmd_len;
  assign bus3.wdata       = wdata;
  assign bus3.wdata_valid = wdata_valid & sel;

  mem_access_master #(.READ_LATENCY(1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));
  mem_access_master #(.READ_LATENCY(3)) u_dut3 (.clock(clock), .reset(reset), .bus(bus3));

  // Memory models: rE in cycle k -> dataOut holds the word in cycle k+L.
  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic [31:0] d1;
  logic [31:0] d3 [3];

  always @(posedge clock) begin
    if (bus1.mem_wE) mem1[bus1.mem_address] <= bus1.mem_data;
    d1 <= bus1.mem_rE ? mem1[bus1.mem_address] : 32'hBAD0_0001;
    if (bus3.mem_wE) mem3[bus3.mem_address] <= bus3.mem_data;
    d3[0] <= bus3.mem_rE ? mem3[bus3.mem_address] : 32'hBAD0_0003;
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign bus1.mem_dataOut = d1;
  assign bus3.mem_dataOut = d3[2];

  logic        m_cmd_ready, m_wdata_ready, m_rdata_valid, m_done, m_mem_rE, m_mem_wE;
  logic [5:0]  m_mem_address;
  logic [31:0] m_mem_data, m_rdata;
  assign m_cmd_ready   = sel ? bus3.cmd_ready   : bus1.cmd_ready;
  assign m_wdata_ready = sel ? bus3.wdata_ready : bus1.wdata_ready;
  assign m_rdata_valid = sel ? bus3.rdata_valid : bus1.rdata_valid;
  assign m_done        = sel ? bus3.done        : bus1.done;
  assign m_mem_rE      = sel ? bus3.mem_rE      : bus1.mem_rE;
  assign m_mem_wE      = sel ? bus3.mem_wE      : bus1.mem_wE;
  assign m_mem_address = sel ? bus3.mem_address : bus1.mem_address;
  assign m_mem_data    = sel ? bus3.mem_data    : bus1.mem_data;
  assign m_rdata       = sel ? bus3.rdata       : bus1.rdata;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          we_cyc[$];
  logic [5:0]  we_addr[$];
  logic [31:0] we_data[$];
  int          re_cyc[$];
  logic [5:0]  re_addr[$];
  int          rv_cyc[$];
  logic [31:0] rv_data[$];
  int          done_cyc[$];
  int          n_accept = 0;
  int          n_excl = 0;

  always @(negedge clock) begin
    if (m_mem_wE) begin
      we_cyc.push_back(cyc); we_addr.push_back(m_mem_address); we_data.push_back(m_mem_data);
    end
    if (m_mem_rE) begin
      re_cyc.push_back(cyc); re_addr.push_back(m_mem_address);
    end
    if (m_rdata_valid) begin
      rv_cyc.push_back(cyc); rv_data.push_back(m_rdata);
    end
    if (m_done) done_cyc.push_back(cyc);
    if (cmd_valid && m_cmd_ready) n_accept++;
    if ((bus1.mem_rE && bus1.mem_wE) || (bus3.mem_rE && bus3.mem_wE)) n_excl++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    we_cyc.delete(); we_addr.delete(); we_data.delete();
    re_cyc.delete(); re_addr.delete();
    rv_cyc.delete(); rv_data.delete();
    done_cyc.delete();
    n_accept = 0;
  endtask

  // Returns with cyc equal to the accepting edge (cycle 0 of the burst).
  task automatic issue(input logic w, input logic [5:0] a, input logic [3:0] l, output int acc);
    int t;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    t = 0;
    while (!m_cmd_ready && t < 100) begin tick(); t++; end
    if (t >= 100) check("cmd_ready_timeout", 32'(m_cmd_ready), 1);
    tick();
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  logic [31:0] words [16];

  task automatic push_words(input int n, input int stall_after, input int stall_len,
                            input logic [5:0] start);
    for (int i = 0; i < n; i++) begin
      wdata = words[i]; wdata_valid = 1'b1;
      tick();
      if (i == stall_after) begin
        wdata_valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_wE", 32'(m_mem_wE), 0);
          check("stall_addr", 32'(m_mem_address), 32'(start + 6'(i)));
        end
      end
    end
    wdata_valid = 1'b0;
  endtask

  task automatic wait_done(input int want, input int budget);
    int t;
    t = 0;
    while (done_cyc.size() < want && t < budget) begin tick(); t++; end
    if (done_cyc.size() < want) check("done_timeout", done_cyc.size(), want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, acc2, ready_hi, t;
    logic [5:0] exp_addr [4];

    sel = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata = '0; wdata_valid = 1'b0; reset = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_rdata", bus1.rdata, 0);
    check("rst_mem_data", bus1.mem_data, 0);
    check("rst_ctl", 32'({bus1.wdata_ready, bus1.rdata_valid, bus1.done,
                          bus1.mem_rE, bus1.mem_wE, bus1.mem_address}), 0);
    check("rst_ctl_l3", 32'({bus3.wdata_ready, bus3.rdata_valid, bus3.done,
                             bus3.mem_rE, bus3.mem_wE, bus3.mem_address}), 0);
    reset = 1'b0;
    tick();
    check("rst_cmd_ready", 32'(m_cmd_ready), 1);

    // Single write then read
    clear_logs();
    words[0] = 32'hDEAD_BEEF;
    issue(1'b1, 6'd5, 4'd0, acc);
    check("w1_wdata_ready", 32'(m_wdata_ready), 1);
    push_words(1, -1, 0, 6'd5);
    check("w1_ready_in_done", 32'(m_cmd_ready), 0);
    tick();
    check("w1_ready_after", 32'(m_cmd_ready), 1);
    wait_done(1, 20);
    check("w1_we_count", we_cyc.size(), 1);
    if (we_cyc.size() > 0) begin
      check("w1_addr", 32'(we_addr[0]), 5);
      check("w1_data", we_data[0], 32'hDEAD_BEEF);
      check("w1_we_cycle", we_cyc[0] - acc, 1);
    end
    if (done_cyc.size() > 0) check("w1_done_cycle", done_cyc[0] - acc, 1);

    clear_logs();
    issue(1'b0, 6'd5, 4'd0, acc);
    wait_done(1, 20);
    tick();
    check("r1_rv_count", rv_cyc.size(), 1);
    if (rv_cyc.size() > 0 && re_cyc.size() > 0 && done_cyc.size() > 0) begin
      check("r1_data", rv_data[0], 32'hDEAD_BEEF);
      check("r1_latency", rv_cyc[0] - re_cyc[0], 2);
      check("r1_addr", 32'(re_addr[0]), 5);
      check("r1_done_cycle", done_cyc[0] - acc, 3);
      check("r1_done_with_rv", done_cyc[0], rv_cyc[0]);
    end

    // Burst with wrap
    exp_addr[0] = 6'd62; exp_addr[1] = 6'd63; exp_addr[2] = 6'd0; exp_addr[3] = 6'd1;
    clear_logs();
    for (int i = 0; i < 4; i++) words[i] = 32'(i + 1);
    issue(1'b1, 6'd62, 4'd3, acc);
    push_words(4, -1, 0, 6'd62);
    wait_done(1, 20);
    check("w4_we_count", we_cyc.size(), 4);
    for (int i = 0; i < 4; i++)
      if (we_addr.size() > i) check("w4_addr", 32'(we_addr[i]), 32'(exp_addr[i]));
    if (done_cyc.size() > 0) check("w4_done_cycle", done_cyc[0] - acc, 4);

    clear_logs();
    issue(1'b0, 6'd62, 4'd3, acc);
    wait_done(1, 30);
    tick();
    check("r4_rv_count", rv_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (rv_cyc.size() > i) begin
        check("r4_data", rv_data[i], 32'(i + 1));
        check("r4_rv_cycle", rv_cyc[i] - acc, 3 + i);
      end
      if (re_addr.size() > i) check("r4_addr", 32'(re_addr[i]), 32'(exp_addr[i]));
    end
    if (done_cyc.size() > 0) check("r4_done_cycle", done_cyc[0] - acc, 6);

    // Write stalls: 2 idle cycles between word 1 and word 2
    clear_logs();
    words[0] = 32'hA0A0_0001; words[1] = 32'hA0A0_0002; words[2] = 32'hA0A0_0003;
    issue(1'b1, 6'd10, 4'd2, acc);
    push_words(3, 0, 2, 6'd10);
    wait_done(1, 20);
    check("ws_we_count", we_cyc.size(), 3);
    if (we_cyc.size() >= 3) begin
      check("ws_cyc0", we_cyc[0] - acc, 1);
      check("ws_cyc1", we_cyc[1] - acc, 4);
      check("ws_cyc2", we_cyc[2] - acc, 5);
      check("ws_addr1", 32'(we_addr[1]), 11);
      check("ws_addr2", 32'(we_addr[2]), 12);
      check("ws_data2", we_data[2], 32'hA0A0_0003);
    end
    if (done_cyc.size() > 0) check("ws_done_cycle", done_cyc[0] - acc, 5);

    // Handshake hold-off: cmd_valid held through a 2-word read
    tick();
    clear_logs();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'd62; cmd_len = 4'd1;
    check("ho_ready_start", 32'(m_cmd_ready), 1);
    tick();
    acc1 = cyc;
    ready_hi = 0; t = 0;
    while (done_cyc.size() == 0 && t < 50) begin
      if (m_cmd_ready) ready_hi++;
      tick(); t++;
    end
    check("ho_ready_low", ready_hi, 0);
    check("ho_ready_after_done", 32'(m_cmd_ready), 1);
    tick();
    acc2 = cyc;
    cmd_valid = 1'b0;
    wait_done(2, 30);
    tick();
    check("ho_accepts", n_accept, 2);
    if (done_cyc.size() >= 2) begin
      check("ho_done1", done_cyc[0] - acc1, 4);
      check("ho_second_accept", acc2 - done_cyc[0], 2);
      check("ho_done2", done_cyc[1] - acc2, 4);
    end
    check("ho_rv_count", rv_cyc.size(), 4);
    if (rv_data.size() >= 4) begin
      check("ho_data0", rv_data[0], 1);
      check("ho_data3", rv_data[3], 2);
    end

    // Reset during the second word of a 16-word read
    clear_logs();
    issue(1'b0, 6'd0, 4'd15, acc);
    tick(); tick();
    check("mr_re_before", 32'(m_mem_rE), 1);
    reset = 1'b1;
    #1;
    check("mr_outputs", 32'({m_mem_rE, m_mem_wE, m_rdata_valid, m_done, m_mem_address}), 0);
    clear_logs();
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
    check("mr_no_rv", rv_cyc.size(), 0);
    check("mr_no_done", done_cyc.size(), 0);
    check("mr_no_re", re_cyc.size(), 0);
    check("mr_ready", 32'(m_cmd_ready), 1);

    // READ_LATENCY = 3 instance
    sel = 1'b1;
    tick();
    clear_logs();
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    issue(1'b1, 6'd20, 4'd3, acc);
    push_words(4, -1, 0, 6'd20);
    wait_done(1, 20);
    tick();
    clear_logs();
    issue(1'b0, 6'd20, 4'd3, acc);
    wait_done(1, 40);
    tick();
    check("l3_rv_count", rv_cyc.size(), 4);
    check("l3_re_count", re_cyc.size(), 4);
    if (rv_cyc.size() >= 4 && re_cyc.size() >= 1 && done_cyc.size() >= 1) begin
      check("l3_first_latency", rv_cyc[0] - re_cyc[0], 4);
      for (int i = 0; i < 4; i++) begin
        check("l3_rv_cycle", rv_cyc[i] - acc, 5 + i);
        check("l3_data", rv_data[i], 32'h11 * 32'(i + 1));
      end
      check("l3_done_cycle", done_cyc[0] - acc, 8);
      check("l3_done_with_rv", done_cyc[0], rv_cyc[3]);
    end

    check("mutual_exclusion", n_excl, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
